// File: rtl/my_uart_rx7to7_pkg.sv
// Shared UART definitions for the 7-bit receiver and its transmitter
// counterpart.
// Contents:
//   BPS*        - baud divisors; one bit period is (divisor + 1) clk cycles
//   ctl_to_div  - maps the 3-bit uart_ctl baud select onto a divisor
//   rx_state_e  - receiver FSM state encoding
package my_uart_rx7to7_pkg;

    localparam logic [12:0] BPS9600   = 13'd5208;
    localparam logic [12:0] BPS19200  = 13'd2603;
    localparam logic [12:0] BPS38400  = 13'd1301;
    localparam logic [12:0] BPS57600  = 13'd867;
    localparam logic [12:0] BPS115200 = 13'd434;
    localparam logic [12:0] BPS256000 = 13'd195;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Unused select codes 6 and 7 fall back to the slowest rate.
    function automatic logic [12:0] ctl_to_div(input logic [2:0] ctl);
        logic [12:0] div;
        case (ctl)
            3'd0:    div = BPS9600;
            3'd1:    div = BPS19200;
            3'd2:    div = BPS38400;
            3'd3:    div = BPS57600;
            3'd4:    div = BPS115200;
            3'd5:    div = BPS256000;
            default: div = BPS9600;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/my_uart_rx7to7_if.sv
// Serial line, baud select and received-character interface of the
// 7-bit UART receiver.
// Signals:
//   rs_rx     - asynchronous serial line, idles high
//   uart_ctl  - baud-rate select
//   data_in   - last correctly framed character
//   data_sign - one-cycle strobe, data_in updated
//   frame_err - one-cycle strobe, stop bit sampled low
//   busy      - receiver not idle
// Modports: master drives the line and select, slave is the receiver.
interface my_uart_rx7to7_if;

    logic       rs_rx;
    logic [2:0] uart_ctl;
    logic [6:0] data_in;
    logic       data_sign;
    logic       frame_err;
    logic       busy;

    modport master (
        output rs_rx,
        output uart_ctl,
        input  data_in,
        input  data_sign,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rs_rx,
        input  uart_ctl,
        output data_in,
        output data_sign,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/my_uart_rx7to7_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   d          - asynchronous input
//   q          - synchronized output
// RST_VAL sets the value both flops take in reset (1 for an idle-high line).
module my_uart_rx7to7_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/my_uart_rx7to7.sv
// UART receiver for 7-bit frames: 1 start, 7 data (LSB first), 1 stop,
// no parity. Bit timing follows the uart_ctl divisor latched at the start
// edge; start is re-checked at mid bit, data and stop are sampled one full
// bit period apart after that.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - slave side of my_uart_rx7to7_if (rs_rx, uart_ctl in;
//                data_in, data_sign, frame_err, busy out)
module my_uart_rx7to7
    import my_uart_rx7to7_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    my_uart_rx7to7_if.slave   bus
);

    logic        rx_s;
    logic        rx_d_r;
    logic        fall_s;
    logic [12:0] half_s;

    rx_state_e   state_r;
    logic [12:0] cnt_r;
    logic [2:0]  bit_idx_r;
    logic [12:0] div_r;
    logic [6:0]  shift_r;
    logic [6:0]  data_r;
    logic        sign_r;
    logic        err_r;
    logic        busy_r;

    my_uart_rx7to7_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rs_rx),
        .q     (rx_s)
    );

    // History flop for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d_r <= 1'b1;
        end else begin
            rx_d_r <= rx_s;
        end
    end

    // A held-low line never re-triggers; only a fresh 1-to-0 edge does.
    assign fall_s = rx_d_r & ~rx_s;
    assign half_s = {1'b0, div_r[12:1]};

    // Receive FSM with counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 13'd0;
            bit_idx_r <= 3'd0;
            div_r     <= BPS9600;
            shift_r   <= 7'd0;
            data_r    <= 7'd0;
            sign_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            sign_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r     <= 13'd0;
                    bit_idx_r <= 3'd0;
                    if (fall_s) begin
                        // Divisor is frozen for the whole frame.
                        div_r   <= ctl_to_div(bus.uart_ctl);
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == half_s) begin
                        cnt_r <= 13'd0;
                        if (!rx_s) begin
                            state_r <= DATA;
                        end else begin
                            // Line back high at mid start bit: glitch.
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 13'd1;
                    end
                end
                DATA: begin
                    if (cnt_r == div_r) begin
                        shift_r[bit_idx_r] <= rx_s;
                        cnt_r              <= 13'd0;
                        if (bit_idx_r == 3'd6) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 13'd1;
                    end
                end
                STOP: begin
                    if (cnt_r == div_r) begin
                        // Leave at mid stop bit so a back-to-back start
                        // edge is not missed.
                        cnt_r   <= 13'd0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (rx_s) begin
                            data_r <= shift_r;
                            sign_r <= 1'b1;
                        end else begin
                            err_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 13'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 13'd0;
                    bit_idx_r <= 3'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_in   = data_r;
    assign bus.data_sign = sign_r;
    assign bus.frame_err = err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_my_uart_rx7to7.sv
// Self-checking bench for my_uart_rx7to7: a table of whole frames with
// expected strobe counts and data, then hand-written sequences for timing,
// glitch, framing error with held-low line, back-to-back frames, mid-frame
// baud switch, loopback of random characters and reset during a frame.
`timescale 1ns/1ps
module tb_my_uart_rx7to7;
    import my_uart_rx7to7_pkg::*;

    logic clk;
    logic rst_n;

    my_uart_rx7to7_if u_if ();

    my_uart_rx7to7 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int sign_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int rise_cnt  = 0;
    logic busy_prev = 1'b0;
    logic [6:0] got_q[$];

    // Strobe monitor.
    always @(negedge clk) begin
        if (u_if.data_sign) begin
            sign_cnt <= sign_cnt + 1;
            got_q.push_back(u_if.data_in);
        end
        if (u_if.frame_err) err_cnt <= err_cnt + 1;
        if (u_if.data_sign && u_if.frame_err) both_cnt <= both_cnt + 1;
        if (u_if.busy && !busy_prev) rise_cnt <= rise_cnt + 1;
        busy_prev <= u_if.busy;
    end

    // Watchdog.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    function automatic int bench_div(input int ctl);
        case (ctl)
            1:       return 2603;
            2:       return 1301;
            3:       return 867;
            4:       return 434;
            5:       return 195;
            default: return 5208;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one frame; optionally change uart_ctl at the start of bit sw_bit.
    task automatic send_frame(input logic [6:0] ch, input logic stop,
                              input int ctl, input int sw_bit, input int new_ctl);
        int bl;
        logic v;
        bl = bench_div(ctl) + 1;
        u_if.uart_ctl = ctl[2:0];
        for (int b = 0; b < 9; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b < 8)  v = ch[b-1];
            else             v = stop;
            u_if.rs_rx = v;
            if (b == sw_bit) u_if.uart_ctl = new_ctl[2:0];
            repeat (bl) @(negedge clk);
        end
    endtask

    typedef struct {
        int         ctl;
        logic [6:0] ch;
        logic       stop;
        int         exp_sign;
        int         exp_err;
        logic [6:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int sc, ec, rc, n;
        logic [6:0] ch, prev;

        vecs[0] = '{4, 7'h2A, 1'b1, 1, 0, 7'h2A};
        vecs[1] = '{5, 7'h3A, 1'b0, 0, 1, 7'h2A};
        vecs[2] = '{5, 7'h00, 1'b1, 1, 0, 7'h00};
        vecs[3] = '{5, 7'h7F, 1'b1, 1, 0, 7'h7F};
        vecs[4] = '{3, 7'h2B, 1'b1, 1, 0, 7'h2B};
        vecs[5] = '{5, 7'h40, 1'b0, 0, 1, 7'h2B};
        vecs[6] = '{5, 7'h01, 1'b1, 1, 0, 7'h01};

        rst_n = 1'b0;
        u_if.rs_rx = 1'b1;
        u_if.uart_ctl = 3'd4;
        repeat (3) @(negedge clk);
        check("rst_data_in", int'(u_if.data_in), 0);
        check("rst_data_sign", int'(u_if.data_sign), 0);
        check("rst_frame_err", int'(u_if.frame_err), 0);
        check("rst_busy", int'(u_if.busy), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int c = 0; c < 8; c++) begin
            logic [2:0] c3;
            c3 = c[2:0];
            check($sformatf("div_ctl%0d", c), int'(ctl_to_div(c3)), bench_div(c));
        end

        // Table of frames.
        for (int i = 0; i < 7; i++) begin
            sc = sign_cnt; ec = err_cnt;
            send_frame(vecs[i].ch, vecs[i].stop, vecs[i].ctl, -1, 0);
            u_if.rs_rx = 1'b1;
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_sign", i), sign_cnt - sc, vecs[i].exp_sign);
            check($sformatf("vec%0d_err", i), err_cnt - ec, vecs[i].exp_err);
            check($sformatf("vec%0d_data", i), int'(u_if.data_in), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), int'(u_if.busy), 0);
        end

        // 0x55 at 115200: busy rise/fall timing from start-bit drive.
        sc = sign_cnt; ec = err_cnt;
        fork
            send_frame(7'h55, 1'b1, 4, -1, 0);
            begin
                n = 0;
                while (!u_if.busy && n < 100) begin @(negedge clk); n++; end
                check("busy_rise_cycle", n, 3);
                while (u_if.busy && n < 5000) begin @(negedge clk); n++; end
                check("busy_fall_cycle", n, 3701);
            end
        join
        repeat (20) @(negedge clk);
        check("h55_sign", sign_cnt - sc, 1);
        check("h55_err", err_cnt - ec, 0);
        check("h55_data", int'(u_if.data_in), 'h55);

        // 100-cycle glitch at 115200.
        sc = sign_cnt; ec = err_cnt;
        u_if.rs_rx = 1'b0;
        n = 0;
        fork
            begin repeat (100) @(negedge clk); u_if.rs_rx = 1'b1; end
            begin
                while (!u_if.busy && n < 100) begin @(negedge clk); n++; end
                while (u_if.busy && n < 1000) begin @(negedge clk); n++; end
            end
        join
        check("glitch_busy_fall_cycle", n, 221);
        repeat (300) @(negedge clk);
        check("glitch_sign", sign_cnt - sc, 0);
        check("glitch_err", err_cnt - ec, 0);

        // Framing error at 38400, then line held low.
        sc = sign_cnt; ec = err_cnt; rc = rise_cnt;
        send_frame(7'h3A, 1'b0, 2, -1, 0);
        repeat (3 * 1302) @(negedge clk);
        check("ferr_err", err_cnt - ec, 1);
        check("ferr_sign", sign_cnt - sc, 0);
        check("ferr_data_kept", int'(u_if.data_in), 'h55);
        check("held_low_no_restart", rise_cnt - rc, 1);
        check("held_low_busy", int'(u_if.busy), 0);
        u_if.rs_rx = 1'b1;
        repeat (50) @(negedge clk);
        sc = sign_cnt;
        send_frame(7'h4D, 1'b1, 5, -1, 0);
        repeat (20) @(negedge clk);
        check("after_ferr_sign", sign_cnt - sc, 1);
        check("after_ferr_data", int'(u_if.data_in), 'h4D);

        // Back-to-back frames with no idle gap.
        got_q.delete();
        send_frame(7'h00, 1'b1, 5, -1, 0);
        send_frame(7'h7F, 1'b1, 5, -1, 0);
        send_frame(7'h2B, 1'b1, 5, -1, 0);
        repeat (20) @(negedge clk);
        check("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_0", int'(got_q[0]), 'h00);
            check("b2b_1", int'(got_q[1]), 'h7F);
            check("b2b_2", int'(got_q[2]), 'h2B);
        end

        // Baud select switched mid-frame: current frame unaffected.
        sc = sign_cnt;
        send_frame(7'h5A, 1'b1, 5, 4, 0);
        repeat (20) @(negedge clk);
        check("midswitch_sign", sign_cnt - sc, 1);
        check("midswitch_data", int'(u_if.data_in), 'h5A);

        // Loopback of random characters at the faster rates.
        for (int r = 0; r < 7; r++) begin
            int ctl;
            ctl = (r < 4) ? 5 : ((r < 6) ? 4 : 3);
            ch = 7'($urandom_range(0, 127));
            sc = sign_cnt;
            send_frame(ch, 1'b1, ctl, -1, 0);
            repeat (20) @(negedge clk);
            check($sformatf("loop%0d_sign", r), sign_cnt - sc, 1);
            check($sformatf("loop%0d_data", r), int'(u_if.data_in), int'(ch));
        end

        // Reset during data bit 3 at 115200; hold reset to end of frame.
        send_frame(7'h6C, 1'b1, 5, -1, 0);
        repeat (20) @(negedge clk);
        prev = u_if.data_in;
        check("pre_reset_data", int'(prev), 'h6C);
        sc = sign_cnt; ec = err_cnt;
        fork
            send_frame(7'h6C, 1'b1, 4, -1, 0);
            begin
                repeat (4 * 435 + 217) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("midrst_data_in", int'(u_if.data_in), 0);
                check("midrst_busy", int'(u_if.busy), 0);
                check("midrst_sign", int'(u_if.data_sign), 0);
                check("midrst_err", int'(u_if.frame_err), 0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_strobe", (sign_cnt - sc) + (err_cnt - ec), 0);
        sc = sign_cnt;
        send_frame(7'h11, 1'b1, 4, -1, 0);
        repeat (20) @(negedge clk);
        check("post_rst_sign", sign_cnt - sc, 1);
        check("post_rst_data", int'(u_if.data_in), 'h11);

        check("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
